// File: rtl/kamacore_pkg.sv
// Shared widths and controller state encoding for the kamacore RAM block.
package kamacore_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_e;

  // Index width for an array of 'depth' words; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/kamacore_rsp_pipe.sv
// Fixed-latency response delay line: valid/err/data shifted DEPTH stages.
module kamacore_rsp_pipe
  import kamacore_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_WIDTH,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      err_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= valid_i & err_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  // Data needs no reset: the outputs are qualified by the reset valid bits.
  always_ff @(posedge clk) begin
    data_q[0] <= valid_i ? data_i : '0;
    for (int i = 1; i < DEPTH; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign err_o   = valid_q[DEPTH-1] & err_q[DEPTH-1];
  assign data_o  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/kamacore_ram_pipe.sv
// Dual-port RAM (A read/write, B read-only) with fixed-latency responses
// and an optional zero-fill sequence after reset.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_INIT | clearing word init_cnt_q each cycle; ports not ready
//   ST_RUN  | normal operation; both ports accept one request/cycle
module kamacore_ram_pipe
  import kamacore_pkg::*;
#(
  parameter int DATA_WIDTH     = CPU_WIDTH,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int RAM_SIZE       = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int INIT_CLEAR     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_req_valid,
  output logic                      a_req_ready,
  input  logic                      a_we,
  input  logic [DATA_WIDTH/8-1:0]   a_be,
  input  logic [MEM_ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]     a_wdata,
  output logic                      a_rsp_valid,
  output logic                      a_rsp_err,
  output logic [DATA_WIDTH-1:0]     a_rdata,
  input  logic                      b_req_valid,
  output logic                      b_req_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] b_addr,
  output logic                      b_rsp_valid,
  output logic                      b_rsp_err,
  output logic [DATA_WIDTH-1:0]     b_rdata,
  output logic                      busy
);

  localparam int          BE_W       = DATA_WIDTH / 8;
  localparam int          IDX_W      = idx_width(RAM_SIZE);
  localparam int unsigned RAM_SIZE_U = RAM_SIZE;
  localparam ram_state_e  RST_STATE  = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  ram_state_e       state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [RAM_SIZE];

  logic                  a_acc, b_acc;
  logic                  a_oob, b_oob;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;

  logic [BE_W-1:0]       wr_be;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(RAM_SIZE - 1)) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RST_STATE;
    endcase
  end

  assign busy        = (state_q == ST_INIT);
  assign a_req_ready = ~busy;
  assign b_req_ready = ~busy;

  assign a_acc = a_req_valid & a_req_ready;
  assign b_acc = b_req_valid & b_req_ready;

  // Out-of-range addresses are steered to word 0 so the array index stays legal.
  assign a_oob = (32'(a_addr) >= RAM_SIZE_U);
  assign b_oob = (32'(b_addr) >= RAM_SIZE_U);
  assign a_idx = a_oob ? '0 : a_addr[IDX_W-1:0];
  assign b_idx = b_oob ? '0 : b_addr[IDX_W-1:0];

  // Both reads sample the array before the edge, giving old data on collision.
  assign a_rd_word = a_oob ? '0 : mem_q[a_idx];
  assign b_rd_word = b_oob ? '0 : mem_q[b_idx];

  always_comb begin
    wr_be   = '0;
    wr_idx  = a_idx;
    wr_data = a_wdata;
    if (state_q == ST_INIT) begin
      wr_be   = '1;
      wr_idx  = init_cnt_q;
      wr_data = '0;
    end else if (a_acc && a_we && !a_oob) begin
      wr_be = a_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) begin
        mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  kamacore_rsp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY)
  ) u_a_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (a_acc),
    .err_i   (a_oob),
    .data_i  (a_rd_word),
    .valid_o (a_rsp_valid),
    .err_o   (a_rsp_err),
    .data_o  (a_rdata)
  );

  kamacore_rsp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY)
  ) u_b_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (b_acc),
    .err_i   (b_oob),
    .data_i  (b_rd_word),
    .valid_o (b_rsp_valid),
    .err_o   (b_rsp_err),
    .data_o  (b_rdata)
  );

endmodule

// File: tb/tb_kamacore_ram_pipe.sv
// Directed bench for kamacore_ram_pipe with a per-port expected-response queue.
module tb_kamacore_ram_pipe;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int RS  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_req_valid, a_req_ready, a_we;
  logic [3:0]    a_be;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_rsp_valid, a_rsp_err;
  logic [DW-1:0] a_rdata;
  logic          b_req_valid, b_req_ready;
  logic [AW-1:0] b_addr;
  logic          b_rsp_valid, b_rsp_err;
  logic [DW-1:0] b_rdata;
  logic          busy;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  exp_t          a_q[$];
  exp_t          b_q[$];
  logic [DW-1:0] model [RS];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  kamacore_ram_pipe #(
    .DATA_WIDTH     (DW),
    .MEM_ADDR_WIDTH (AW),
    .RAM_SIZE       (RS),
    .READ_LATENCY   (LAT),
    .INIT_CLEAR     (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_we        (a_we),
    .a_be        (a_be),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_err   (a_rsp_err),
    .a_rdata     (a_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_addr      (b_addr),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_err   (b_rsp_err),
    .b_rdata     (b_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests at a negedge; record expectations from the model.
  task automatic step(input logic av, input logic awe, input logic [3:0] abe,
                      input logic [AW-1:0] aa, input logic [DW-1:0] awd,
                      input logic bv, input logic [AW-1:0] ba, input bit expect_rsp);
    exp_t e;
    a_req_valid = av;
    a_we        = awe;
    a_be        = abe;
    a_addr      = aa;
    a_wdata     = awd;
    b_req_valid = bv;
    b_addr      = ba;
    if (expect_rsp) begin
      if (bv) begin
        e.err  = (32'(ba) >= RS);
        e.data = e.err ? '0 : model[ba[3:0]];
        e.cyc  = 32'(cyc + LAT);
        b_q.push_back(e);
      end
      if (av) begin
        e.err  = (32'(aa) >= RS);
        e.data = e.err ? '0 : model[aa[3:0]];
        e.cyc  = 32'(cyc + LAT);
        a_q.push_back(e);
        if (awe && !e.err) begin
          for (int i = 0; i < 4; i++) begin
            if (abe[i]) model[aa[3:0]][8*i +: 8] = awd[8*i +: 8];
          end
        end
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_rsp_valid === 1'b1) begin
        chk("a_rsp_expected", 32'(a_q.size() > 0), 32'd1);
        if (a_q.size() > 0) begin
          e = a_q.pop_front();
          chk("a_rdata", a_rdata, e.data);
          chk("a_rsp_err", 32'(a_rsp_err), 32'(e.err));
          chk("a_latency", 32'(cyc), e.cyc);
        end
      end else begin
        chk("a_idle_rdata", a_rdata, 32'd0);
        chk("a_idle_err", 32'(a_rsp_err), 32'd0);
      end
      if (b_rsp_valid === 1'b1) begin
        chk("b_rsp_expected", 32'(b_q.size() > 0), 32'd1);
        if (b_q.size() > 0) begin
          e = b_q.pop_front();
          chk("b_rdata", b_rdata, e.data);
          chk("b_rsp_err", 32'(b_rsp_err), 32'(e.err));
          chk("b_latency", 32'(cyc), e.cyc);
        end
      end else begin
        chk("b_idle_rdata", b_rdata, 32'd0);
        chk("b_idle_err", 32'(b_rsp_err), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    a_req_valid = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req_valid = 1'b0; b_addr = '0;

    // Power-on reset: outputs zero, busy high.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_a_ready", 32'(a_req_ready), 32'd0);
    chk("rst_b_ready", 32'(b_req_ready), 32'd0);
    chk("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clear phase: busy for RS cycles; a request during it must be ignored.
    for (int i = 0; i < RS; i++) begin
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_a_ready", 32'(a_req_ready), 32'd0);
      step(i == 3, 1'b0, 4'h0, AW'(i), '0, i == 3, AW'(1), 1'b0);
    end
    for (int i = 0; i < RS; i++) model[i] = '0;
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_a_ready", 32'(a_req_ready), 32'd1);
    chk("run_b_ready", 32'(b_req_ready), 32'd1);

    // Every word reads zero after the clear, on both ports.
    for (int i = 0; i < RS; i++) step(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b1, AW'(RS - 1 - i), 1'b1);

    // Write then back-to-back read; byte-masked overwrite.
    step(1'b1, 1'b1, 4'hF, AW'(5), 32'hDEADBEEF, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 4'h0, AW'(5), '0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 4'b0101, AW'(5), 32'h11223344, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 4'h0, AW'(5), '0, 1'b1, AW'(5), 1'b1);

    // Same-cycle write on A and read on B of one address.
    step(1'b1, 1'b1, 4'hF, AW'(3), 32'hAAAA5555, 1'b1, AW'(3), 1'b1);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, AW'(3), 1'b1);

    // All-zero byte enables still respond but change nothing.
    step(1'b1, 1'b1, 4'h0, AW'(7), 32'hFFFFFFFF, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 4'h0, AW'(7), '0, 1'b1, AW'(7), 1'b1);

    // Out-of-range accesses, then a full readback to show no word changed.
    step(1'b1, 1'b0, 4'h0, AW'(20), '0, 1'b1, AW'(20), 1'b1);
    step(1'b1, 1'b1, 4'hF, AW'(20), 32'h12345678, 1'b1, AW'(1023), 1'b1);
    for (int i = 0; i < RS; i++) step(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b1, AW'(i), 1'b1);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10 && (a_q.size() != 0 || b_q.size() != 0); k++) @(negedge clk);
    chk("drain_a", 32'(a_q.size()), 32'd0);
    chk("drain_b", 32'(b_q.size()), 32'd0);

    // Reset with two reads in flight: they must never appear.
    step(1'b1, 1'b0, 4'h0, AW'(5), '0, 1'b1, AW'(3), 1'b1);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    #1 rst_n = 1'b0;
    a_q.delete();
    b_q.delete();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_a_valid", 32'(a_rsp_valid), 32'd0);
      chk("mid_rst_b_valid", 32'(b_rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < RS; i++) begin
      chk("reinit_busy", 32'(busy), 32'd1);
      step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < RS; i++) model[i] = '0;
    chk("rerun_busy", 32'(busy), 32'd0);

    // Previously written words are zero again after the restarted clear.
    step(1'b1, 1'b0, 4'h0, AW'(5), '0, 1'b1, AW'(3), 1'b1);
    step(1'b1, 1'b0, 4'h0, AW'(7), '0, 1'b1, AW'(5), 1'b1);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10 && (a_q.size() != 0 || b_q.size() != 0); k++) @(negedge clk);
    chk("final_drain_a", 32'(a_q.size()), 32'd0);
    chk("final_drain_b", 32'(b_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
